sine_sequencer: RTL and testbench

Controller for the quarter-wave sine datapath that drives the board-pin DAC outputs. It owns the phase accumulator and quadrant state machine, and it sequences reads of a synchronous quarter-wave magnitude ROM using mirror and negate symmetry. It paces samples with a programmable clock divider and emits offset-binary samples with a valid strobe. Start and stop are handshaked so that the output always parks at midscale.

---
 rtl/sine_sequencer.sv | 154 +++++++++++++++
 tb/tb_sine_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sine_sequencer.sv
// Quarter-wave sine sequencer: phase accumulator, quadrant FSM and mirrored/negated ROM
// reads, paced by a clock divider, with a stop handshake that always parks at midscale.
module sine_sequencer #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 10,
  parameter int DIV_W   = 16,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [DIV_W-1:0]  div,
  input  logic [ADDR_W-1:0] step,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-2:0] rom_data,
  output logic [DATA_W-1:0] sample,
  output logic              sample_valid,
  output logic [1:0]        quadrant,
  output logic              busy
);
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_RUN      = 2'd1;
  localparam logic [1:0] S_STOPPING = 2'd2;
  localparam logic [1:0] S_DRAIN    = 2'd3;

  localparam logic [DATA_W-1:0] MID    = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] MID_M1 = {1'b0, {(DATA_W-1){1'b1}}};

  function automatic logic [DATA_W-1:0] form_sample(input logic [DATA_W-2:0] mag,
                                                    input logic [1:0] q_in,
                                                    input logic mid);
    logic [DATA_W-1:0] m;
    m = {1'b0, mag};
    if (mid) return MID;
    else if (q_in[1]) return MID_M1 - m;
    else return MID + m;
  endfunction

  logic [1:0]        state;
  logic [DIV_W-1:0]  cnt, div_l;
  logic [ADDR_W-1:0] step_l, p;
  logic [1:0]        q;
  logic              wrapped;
  logic [ADDR_W:0]   s;
  logic              active, tick_raw, dc_stop, tick, final_pt, stop_last, issue, carry;
  logic              drain_done;

  logic              vld_p0, mid_p0, last_p0;
  logic [1:0]        q_p0;
  logic [ROM_LAT-1:0] vld_dly, mid_dly, last_dly;
  logic [1:0]        q_dly [ROM_LAT];
  logic              vld_p1, mid_p1, last_p1;
  logic [1:0]        q_p1;

  always_comb begin
    active    = (state == S_RUN) || (state == S_STOPPING);
    tick_raw  = active && (cnt == div_l);
    // Stopping a DC hold skips the remaining ticks and injects a forced midscale sample.
    dc_stop   = (state == S_RUN) && !en && (step_l == '0);
    tick      = tick_raw && !dc_stop;
    // wrapped covers steps that do not land exactly on p=0 after the 3->0 crossing.
    final_pt  = (q == 2'd0) && ((p == '0) || wrapped);
    stop_last = (state == S_STOPPING) && !en && tick && final_pt;
    issue     = tick || dc_stop;
    s         = {1'b0, p} + {1'b0, step_l};
    carry     = s[ADDR_W];
  end

  assign vld_p1     = vld_dly[ROM_LAT-1];
  assign mid_p1     = mid_dly[ROM_LAT-1];
  assign last_p1    = last_dly[ROM_LAT-1];
  assign q_p1       = q_dly[ROM_LAT-1];
  assign drain_done = vld_p1 && last_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      div_l   <= '0;
      step_l  <= '0;
      p       <= '0;
      q       <= 2'd0;
      wrapped <= 1'b0;
      busy    <= 1'b0;
    end else begin
      if (active) cnt <= tick_raw ? '0 : cnt + DIV_W'(1);
      if (tick) begin
        p       <= s[ADDR_W-1:0];
        wrapped <= carry && (q == 2'd3);
        if (carry) q <= q + 2'd1;
        // Frequency parameters only change at a period boundary.
        if (carry && (q == 2'd3)) begin
          div_l  <= div;
          step_l <= step;
        end
      end
      case (state)
        S_IDLE: if (en) begin
          state   <= S_RUN;
          div_l   <= div;
          step_l  <= step;
          p       <= '0;
          q       <= 2'd0;
          cnt     <= '0;
          wrapped <= 1'b0;
          busy    <= 1'b1;
        end
        S_RUN:      if (!en) state <= dc_stop ? S_DRAIN : S_STOPPING;
        S_STOPPING: if (en) state <= S_RUN;
                    else if (stop_last) state <= S_DRAIN;
        default: if (drain_done) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // p0: ROM address issue; p1: ROM data returns; then sample formation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr     <= '0;
      vld_p0       <= 1'b0;
      vld_dly      <= '0;
      sample       <= MID;
      sample_valid <= 1'b0;
      quadrant     <= 2'd0;
    end else begin
      vld_p0 <= issue;
      if (tick) rom_addr <= q[0] ? ~p : p;
      vld_dly[0] <= vld_p0;
      for (int i = 1; i < ROM_LAT; i++) vld_dly[i] <= vld_dly[i-1];
      sample_valid <= vld_p1;
      if (vld_p1) begin
        sample   <= form_sample(rom_data, q_p1, mid_p1);
        quadrant <= q_p1;
      end
    end
  end

  always_ff @(posedge clk) begin
    q_p0        <= q;
    mid_p0      <= dc_stop;
    last_p0     <= stop_last || dc_stop;
    q_dly[0]    <= q_p0;
    mid_dly[0]  <= mid_p0;
    last_dly[0] <= last_p0;
    for (int i = 1; i < ROM_LAT; i++) begin
      q_dly[i]    <= q_dly[i-1];
      mid_dly[i]  <= mid_dly[i-1];
      last_dly[i] <= last_dly[i-1];
    end
  end
endmodule

// File: tb/tb_sine_sequencer.sv
// Scoreboard bench for sine_sequencer: expected samples are queued as each run is
// configured and popped as sample_valid strobes arrive; ROM holds magnitude 4*addr.
module tb_sine_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] div;
  logic [6:0]  step;
  logic [6:0]  rom_addr;
  logic [8:0]  rom_data;
  logic [9:0]  sample;
  logic        sample_valid;
  logic [1:0]  quadrant;
  logic        busy;

  int errors = 0;
  int checks = 0;
  logic [9:0] exp_s [$];
  logic [1:0] exp_q [$];
  logic [9:0] es;
  logic [1:0] eq;
  int mp, mq, mstep;

  sine_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .div(div), .step(step),
    .rom_addr(rom_addr), .rom_data(rom_data), .sample(sample),
    .sample_valid(sample_valid), .quadrant(quadrant), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= {rom_addr, 2'b00};

  task automatic push_model(input int n);
    for (int i = 0; i < n; i++) begin
      int a;
      a = (mq % 2 == 1) ? 127 - mp : mp;
      exp_s.push_back(10'(mq >= 2 ? 511 - 4 * a : 512 + 4 * a));
      exp_q.push_back(2'(mq));
      mp += mstep;
      if (mp >= 128) begin
        mp -= 128;
        mq = (mq + 1) % 4;
      end
    end
  endtask

  task automatic start(input int d, input int st);
    @(negedge clk);
    div = 16'(d); step = 7'(st); en = 1'b1;
    mp = 0; mq = 0; mstep = st;
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0; rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_s.delete(); exp_q.delete();
  endtask

  task automatic test_reset();
    int k;
    rst_n = 1'b0; en = 1'b1; div = 16'd2; step = 7'd1;
    repeat (3) @(negedge clk);
    checks++; if (sample !== 10'd512) begin errors++; $display("FAIL reset_sample got %0d want 512", sample); end
    checks++; if (sample_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sample_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (rom_addr !== 7'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", rom_addr); end
    checks++; if (quadrant !== 2'd0) begin errors++; $display("FAIL reset_quad got %0d want 0", quadrant); end
    rst_n = 1'b1;
    k = 0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL start_busy got %b want 1", busy); end
    while (!sample_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    checks++; if (k != 5) begin errors++; $display("FAIL first_latency got %0d want 5", k); end
    checks++; if (sample !== 10'd512 || quadrant !== 2'd0) begin errors++; $display("FAIL first_sample got %0d want 512", sample); end
  endtask

  task automatic test_full_rate();
    int n, k, last_k, mx, mn, first_k;
    start(0, 1);
    push_model(520);
    n = 0; k = 0; last_k = -1; mx = 0; mn = 2000; first_k = -1;
    while (n < 520 && k < 700) begin
      @(negedge clk);
      if (sample_valid) begin
        es = exp_s.pop_front(); eq = exp_q.pop_front();
        checks++;
        if (sample !== es || quadrant !== eq) begin
          errors++; $display("FAIL full_rate s%0d got %0d/q%0d want %0d/q%0d", n, sample, quadrant, es, eq);
        end
        if (last_k >= 0) begin
          checks++;
          if (k - last_k != 1) begin errors++; $display("FAIL full_rate_gap s%0d got %0d want 1", n, k - last_k); end
        end else first_k = k;
        if (int'(sample) > mx) mx = int'(sample);
        if (int'(sample) < mn) mn = int'(sample);
        last_k = k; n++;
      end
      k++;
    end
    checks++; if (first_k != 3) begin errors++; $display("FAIL full_rate_latency got %0d want 3", first_k); end
    checks++; if (n != 520) begin errors++; $display("FAIL full_rate_count got %0d want 520", n); end
    checks++; if (mx != 1020) begin errors++; $display("FAIL full_rate_peak got %0d want 1020", mx); end
    checks++; if (mn != 3) begin errors++; $display("FAIL full_rate_trough got %0d want 3", mn); end
  endtask

  task automatic test_coarse();
    int tbl [8] = '{0, 32, 64, 96, 127, 95, 63, 31};
    int n, k, last_k, a, qq, ex;
    start(3, 32);
    n = 0; k = 0; last_k = -1;
    while (n < 20 && k < 200) begin
      @(negedge clk);
      if (sample_valid) begin
        a = tbl[n % 8]; qq = (n / 4) % 4;
        ex = (qq >= 2) ? 511 - 4 * a : 512 + 4 * a;
        checks++;
        if (int'(sample) != ex || int'(quadrant) != qq) begin
          errors++; $display("FAIL coarse s%0d got %0d/q%0d want %0d/q%0d", n, sample, quadrant, ex, qq);
        end
        if (last_k >= 0) begin
          checks++;
          if (k - last_k != 4) begin errors++; $display("FAIL coarse_gap s%0d got %0d want 4", n, k - last_k); end
        end
        last_k = k; n++;
      end
      k++;
    end
    checks++; if (n != 20) begin errors++; $display("FAIL coarse_count got %0d want 20", n); end
  endtask

  task automatic test_graceful_stop();
    int n, k, last_s;
    logic lb, pb;
    start(1, 8);
    push_model(65);
    n = 0; k = 0; last_s = -1; lb = 1'b1; pb = 1'b1;
    while (k < 400) begin
      @(negedge clk);
      if (sample_valid) begin
        checks++;
        if (exp_s.size() == 0) begin
          errors++; $display("FAIL stop_extra_strobe got %0d want none", sample);
        end else begin
          es = exp_s.pop_front(); eq = exp_q.pop_front();
          if (sample !== es || quadrant !== eq) begin
            errors++; $display("FAIL stop s%0d got %0d/q%0d want %0d/q%0d", n, sample, quadrant, es, eq);
          end
        end
        pb = lb; lb = busy; last_s = int'(sample); n++;
        if (en && quadrant == 2'd2) en = 1'b0;
      end
      k++;
    end
    checks++; if (n != 65) begin errors++; $display("FAIL stop_count got %0d want 65", n); end
    checks++; if (last_s != 512) begin errors++; $display("FAIL stop_final got %0d want 512", last_s); end
    checks++; if (lb !== 1'b0 || pb !== 1'b1) begin errors++; $display("FAIL stop_busy got last=%b prev=%b want 0/1", lb, pb); end
  endtask

  task automatic test_param_change();
    int n, k;
    start(0, 1);
    push_model(512);
    mstep = 4;
    push_model(40);
    n = 0; k = 0;
    while (n < 552 && k < 700) begin
      @(negedge clk);
      if (sample_valid) begin
        es = exp_s.pop_front(); eq = exp_q.pop_front();
        checks++;
        if (sample !== es || quadrant !== eq) begin
          errors++; $display("FAIL param s%0d got %0d/q%0d want %0d/q%0d", n, sample, quadrant, es, eq);
        end
        n++;
        if (n == 200) step = 7'd4;
      end
      k++;
    end
    checks++; if (n != 552) begin errors++; $display("FAIL param_count got %0d want 552", n); end
  endtask

  task automatic test_en_pulse();
    int n, k, last_k;
    logic restore;
    start(0, 1);
    push_model(300);
    n = 0; k = 0; last_k = -1; restore = 1'b0;
    while (n < 300 && k < 400) begin
      @(negedge clk);
      if (restore) begin en = 1'b1; restore = 1'b0; end
      if (sample_valid) begin
        es = exp_s.pop_front(); eq = exp_q.pop_front();
        checks++;
        if (sample !== es || quadrant !== eq) begin
          errors++; $display("FAIL en_pulse s%0d got %0d/q%0d want %0d/q%0d", n, sample, quadrant, es, eq);
        end
        if (last_k >= 0 && k - last_k != 1) begin
          errors++; $display("FAIL en_pulse_gap s%0d got %0d want 1", n, k - last_k);
        end
        last_k = k; n++;
        if (n == 100) begin en = 1'b0; restore = 1'b1; end
      end
      k++;
    end
    checks++; if (n != 300) begin errors++; $display("FAIL en_pulse_count got %0d want 300", n); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL en_pulse_busy got %b want 1", busy); end
  endtask

  task automatic test_dc_hold();
    int n, k, last_k, post;
    logic lb;
    start(2, 0);
    n = 0; k = 0; last_k = -1;
    while (n < 5 && k < 50) begin
      @(negedge clk);
      if (sample_valid) begin
        checks++;
        if (sample !== 10'd512 || quadrant !== 2'd0) begin errors++; $display("FAIL dc s%0d got %0d want 512", n, sample); end
        if (last_k >= 0 && k - last_k != 3) begin errors++; $display("FAIL dc_gap s%0d got %0d want 3", n, k - last_k); end
        last_k = k; n++;
      end
      k++;
    end
    en = 1'b0;
    post = 0; lb = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (sample_valid) begin
        checks++;
        if (sample !== 10'd512) begin errors++; $display("FAIL dc_final got %0d want 512", sample); end
        lb = busy; post++;
      end
    end
    checks++; if (post != 1) begin errors++; $display("FAIL dc_stop_strobes got %0d want 1", post); end
    checks++; if (lb !== 1'b0) begin errors++; $display("FAIL dc_stop_busy got %b want 0", lb); end
  endtask

  task automatic test_async_reset();
    int n, k, post;
    start(2, 1);
    n = 0; k = 0;
    while (n < 3 && k < 50) begin
      @(negedge clk);
      if (sample_valid) n++;
      k++;
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (sample !== 10'd512 || sample_valid !== 1'b0 || busy !== 1'b0 || rom_addr !== 7'd0 || quadrant !== 2'd0) begin
      errors++; $display("FAIL async_reset got s=%0d v=%b b=%b a=%0d q=%0d want 512/0/0/0/0",
                         sample, sample_valid, busy, rom_addr, quadrant);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    post = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_valid) post++;
    end
    checks++; if (post != 0) begin errors++; $display("FAIL async_pending_strobe got %0d want 0", post); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL async_busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    do_reset();
    test_full_rate();
    do_reset();
    test_coarse();
    do_reset();
    test_graceful_stop();
    test_param_change();
    do_reset();
    test_en_pulse();
    do_reset();
    test_dc_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
